// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and divider constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Clock cycles per bit from a 50 MHz system clock.
    localparam int unsigned BPS_DIV_115200 = 434;
    localparam int unsigned BPS_DIV_9600   = 5208;

    localparam int unsigned BPS_CNT_W = 13;

endpackage

// File: rtl/uart_tx_bps.sv
// Bit-period timer: counts while run_i is high and pulses bit_end_o on the last cycle of each bit.
module uart_tx_bps
    import uart_pkg::*;
#(
    parameter int unsigned BPS_DIV = BPS_DIV_115200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic bit_end_o
);

    localparam logic [BPS_CNT_W-1:0] CntMax = BPS_CNT_W'(BPS_DIV - 1);

    logic [BPS_CNT_W-1:0] cnt_q, cnt_d;

    // End-of-bit pulse, not mid-bit: the FSM advances exactly BPS_DIV cycles after entering a bit.
    assign bit_end_o = run_i && (cnt_q == CntMax);

    // Next count: held at zero while idle, wraps at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned BPS_DIV    = BPS_DIV_115200,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       txd_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       sc_q, sc_d;
    logic       parity_q, parity_d;
    logic       done_q, done_d;
    logic       txd_q, txd_d;
    logic       bit_end;
    logic       accept;

    assign tx_ready_o = (state_q == ST_IDLE);
    assign accept     = tx_valid_i && tx_ready_o;
    assign tx_done_o  = done_q;
    assign txd_o      = txd_q;

    uart_tx_bps #(
        .BPS_DIV(BPS_DIV)
    ) u_bps (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (state_q != ST_IDLE),
        .bit_end_o(bit_end)
    );

    // Next-state, datapath and line level; txd is derived from the next state so the pin is a flop.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        sc_d     = sc_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_START;
                    shift_d  = tx_data_i;
                    parity_d = (^tx_data_i) ^ PARITY_ODD;
                    idx_d    = 3'd0;
                    sc_d     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        sc_d    = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    sc_d    = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if ((STOP_BITS == 2) && !sc_q) begin
                        sc_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unique case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = parity_q;
            default:   txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            sc_q     <= 1'b0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            sc_q     <= sc_d;
            parity_q <= parity_d;
            done_q   <= done_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three instances cover the no-parity and parity/2-stop builds.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       valid_a, valid_b, valid_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       done_a, done_b, done_c;
    logic       txd_a, txd_b, txd_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.BPS_DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid_a),
        .tx_ready_o(rdy_a), .tx_done_o(done_a), .txd_o(txd_a)
    );

    uart_tx_frame #(.BPS_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid_b),
        .tx_ready_o(rdy_b), .tx_done_o(done_b), .txd_o(txd_b)
    );

    uart_tx_frame #(.BPS_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(valid_c),
        .tx_ready_o(rdy_c), .tx_done_o(done_c), .txd_o(txd_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_txd(int s);
        return (s == 0) ? txd_a : (s == 1) ? txd_b : txd_c;
    endfunction

    function automatic logic cur_rdy(int s);
        return (s == 0) ? rdy_a : (s == 1) ? rdy_b : rdy_c;
    endfunction

    function automatic logic cur_done(int s);
        return (s == 0) ? done_a : (s == 1) ? done_b : done_c;
    endfunction

    task automatic set_valid(int s, logic v);
        case (s)
            0:       valid_a = v;
            1:       valid_b = v;
            default: valid_c = v;
        endcase
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        tx_data = 8'h00;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
        for (int i = 0; i < 23; i++) begin
            tick();
            if (i == 2) rst_n = 1'b1;
            for (int s = 0; s < 3; s++) begin
                n_checks++;
                if (cur_txd(s) !== 1'b1 || cur_rdy(s) !== 1'b1 || cur_done(s) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d cycle %0d: txd=%b ready=%b done=%b, required 1 1 0",
                             s, i, cur_txd(s), cur_rdy(s), cur_done(s));
                end
            end
        end
    endtask

    // Sends one byte and checks every cycle of the line, the busy window and the done pulse.
    task automatic test_frame(int s, logic [7:0] data, bit has_par, logic par, int nstop,
                              string name);
        int   len;
        int   b;
        logic e;
        len = (9 + int'(has_par) + nstop) * 4;
        tx_data = data;
        set_valid(s, 1'b1);
        tick();
        set_valid(s, 1'b0);
        tx_data = ~data;
        for (int k = 0; k < len; k++) begin
            b = k / 4;
            if (b == 0)                   e = 1'b0;
            else if (b <= 8)              e = data[b-1];
            else if (has_par && b == 9)   e = par;
            else                          e = 1'b1;
            n_checks++;
            if (cur_txd(s) !== e) begin
                n_fail++;
                $display("FAIL %s txd cycle %0d: got %b, required %b", name, k, cur_txd(s), e);
            end
            n_checks++;
            if (cur_rdy(s) !== 1'b0 || cur_done(s) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: ready=%b done=%b, required 0 0",
                         name, k, cur_rdy(s), cur_done(s));
            end
            tick();
        end
        n_checks++;
        if (cur_done(s) !== 1'b1 || cur_rdy(s) !== 1'b1 || cur_txd(s) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_cycle %0d: done=%b ready=%b txd=%b, required 1 1 1",
                     name, len, cur_done(s), cur_rdy(s), cur_txd(s));
        end
        tick();
        n_checks++;
        if (cur_done(s) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: done=%b, required 0", name, cur_done(s));
        end
    endtask

    task automatic test_back_to_back();
        logic       cap  [100];
        logic       capd [100];
        logic       r;
        int         start2;
        int         ndone;
        int         st;
        logic [7:0] got;
        logic [7:0] want;
        tx_data = 8'h55;
        valid_a = 1'b1;
        tick();
        tx_data = 8'h0F;
        for (int k = 0; k < 100; k++) begin
            cap[k]  = txd_a;
            capd[k] = done_a;
            r       = rdy_a;
            tick();
            if (r) valid_a = 1'b0;
        end
        valid_a = 1'b0;
        n_checks++;
        if (cap[39] !== 1'b1 || cap[40] !== 1'b1 || capd[40] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: txd[39]=%b txd[40]=%b done[40]=%b, required 1 1 1",
                     cap[39], cap[40], capd[40]);
        end
        start2 = -1;
        for (int k = 40; k < 100; k++) begin
            if (start2 < 0 && cap[k] === 1'b0) start2 = k;
        end
        n_checks++;
        if (start2 != 41) begin
            n_fail++;
            $display("FAIL b2b_start2: second start at cycle %0d, required 41", start2);
        end
        for (int f = 0; f < 2; f++) begin
            st   = (f == 0) ? 0 : ((start2 >= 0 && start2 <= 61) ? start2 : 61);
            want = (f == 0) ? 8'h55 : 8'h0F;
            for (int i = 0; i < 8; i++) got[i] = cap[st + 4 * (i + 1) + 2];
            n_checks++;
            if (cap[st + 2] !== 1'b0 || cap[st + 38] !== 1'b1 || got !== want) begin
                n_fail++;
                $display("FAIL b2b_rx frame %0d: start=%b stop=%b byte=%h, required 0 1 %h",
                         f, cap[st + 2], cap[st + 38], got, want);
            end
        end
        ndone = 0;
        for (int k = 0; k < 100; k++) if (capd[k] === 1'b1) ndone++;
        n_checks++;
        if (ndone != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, required 2", ndone);
        end
        repeat (3) tick();
    endtask

    task automatic test_busy_ignore();
        logic       cap  [60];
        logic       capd [60];
        logic       capr [60];
        logic [7:0] got;
        int         ndone;
        int         nbad;
        tx_data = 8'h3C;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cap[k]  = txd_a;
            capd[k] = done_a;
            capr[k] = rdy_a;
            if (k == 10) begin
                tx_data = 8'hFF;
                valid_a = 1'b1;
            end
            if (k == 11) valid_a = 1'b0;
            tick();
        end
        for (int i = 0; i < 8; i++) got[i] = cap[4 * (i + 1) + 2];
        n_checks++;
        if (got !== 8'h3C || cap[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_rx: byte=%h start=%b, required 3c 0", got, cap[2]);
        end
        nbad = 0;
        for (int k = 0; k < 40; k++) if (capr[k] !== 1'b0) nbad++;
        n_checks++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL busy_ready: %0d busy cycles with ready high, required 0", nbad);
        end
        nbad  = 0;
        ndone = 0;
        for (int k = 40; k < 60; k++) if (cap[k] !== 1'b1) nbad++;
        for (int k = 0; k < 60; k++) if (capd[k] === 1'b1) ndone++;
        n_checks++;
        if (nbad != 0 || ndone != 1 || capd[40] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_second_frame: low_after=%0d dones=%0d done40=%b, required 0 1 1",
                     nbad, ndone, capd[40]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nbad;
        tx_data = 8'hC3;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        repeat (17) tick();
        // Cycle 17 lies in data bit 3, which is 0 for 0xC3.
        n_checks++;
        if (txd_a !== 1'b0 || rdy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pre: txd=%b ready=%b, required 0 0", txd_a, rdy_a);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (txd_a !== 1'b1 || rdy_a !== 1'b1 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_edge: txd=%b ready=%b done=%b, required 1 1 0",
                     txd_a, rdy_a, done_a);
        end
        rst_n = 1'b1;
        nbad  = 0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (txd_a !== 1'b1 || done_a !== 1'b0 || rdy_a !== 1'b1) nbad++;
        end
        n_checks++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL midreset_after: %0d cycles not idle or with done, required 0", nbad);
        end
    endtask

    initial begin
        test_reset();
        test_frame(0, 8'hA5, 1'b0, 1'b0, 1, "basic_a5");
        test_frame(1, 8'h07, 1'b1, 1'b0, 2, "odd_par_07");
        test_frame(2, 8'h07, 1'b1, 1'b1, 2, "even_par_07");
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_frame(0, 8'h81, 1'b0, 1'b0, 1, "post_reset_81");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
